rs_enc: RTL and testbench
=========================

Name: rs_enc

Overview:
- Systematic Reed-Solomon RS(204,188) encoder over GF(2^8), DVB flavour. It is the transmit-side counterpart of RS_dec.
- Accepts 188 data bytes per block, one byte per CE strobe. Emits 204 bytes per block: the 188 data bytes passed through, followed by 16 parity bytes.
- Output byte stream is directly consumable by RS_dec, so encoder->decoder loopback is byte-exact.

Parameters:
- N, 204, codeword length in bytes; N-K fixed at 16.
- K, 188, data bytes per codeword; 8-bit block counter sized for N<=255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous active-high reset
- CE  input  1  byte strobe, one-clock pulse per output byte slot; input_byte sampled only when CE=1
- input_byte  input  8  data byte, valid with CE during data phase; ignored during parity phase
- Out_byte  output  8  encoded byte (data pass-through or parity)
- CEO  output  1  one-clock strobe, Out_byte valid
- Valid_out  output  1  high with every CEO belonging to a codeword (data and parity)
- Sync_out  output  1  high with CEO of byte 0 of each codeword
- Par_out  output  1  high with CEO of bytes K..N-1 (parity)

Behaviour:
- Field and generator:
  - Primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
  - Generator g(x) = prod_{i=0..15}(x - alpha^i), monic, coefficients g0..g15 held as constants.
  - Constant multipliers are combinational XOR networks; no ROM, no multicycle arithmetic.
- State:
  - cnt: 8-bit byte counter, 0..N-1.
  - r[0..15]: 16x8-bit parity LFSR.
- Data phase (cnt<K) on CE:
  - fb = input_byte ^ r[15].
  - r[i] <= r[i-1] ^ gmul(fb,g_i) for i=1..15.
  - r[0] <= gmul(fb,g0).
  - Out_byte <= input_byte; Par_out <= 0.
- Parity phase (K<=cnt<N) on CE:
  - Out_byte <= r[15].
  - r[i] <= r[i-1]; r[0] <= 0.
  - Par_out <= 1; input_byte ignored.
- Counter:
  - cnt increments on each CE.
  - At cnt=N-1 it wraps to 0. LFSR is all-zero after the 16th parity shift, so there is no explicit clear.
  - The next CE starts a new codeword with no idle slot required.
- Timing:
  - Latency: CEO, Out_byte and flags registered, asserted exactly one clock after the CE that produced them.
  - CEO width 1 clock. Out_byte and flags hold their value until the next CEO.
- Without CE: no state change; CEO=0.
- Back-to-back CE on consecutive clocks is legal. Throughput is 1 byte/clk, with no minimum spacing.
- Upstream responsibility: supply 204 CE strobes per codeword and present don't-care input during the 16 parity slots. The encoder neither stalls nor backpressures.
- Reset (asynchronous, any time, including mid-codeword):
  - cnt=0, r=0, Out_byte=0, CEO=0, Valid_out=0, Sync_out=0, Par_out=0.
  - The partial codeword is discarded. The first CE after deassertion is data byte 0.
- Valid_out equals CEO once out of reset; kept as a separate port for RS_dec-style interfacing.

Test Plan:
- All-zero block: 188 CE with input_byte=0x00 -> 204 CEO. All Out_byte=0x00. Sync_out on CEO #0 only; Par_out on CEO #188..#203.
- Loopback: 100 random blocks, CE spaced 1-in-8 as in the RS_dec bench, encoder output fed to RS_dec -> 18800 decoded bytes match the source, error count 0.
- Unit impulse: bytes 0..186=0x00, byte 187=0x01 -> parity bytes #188..#203 equal g15,g14,...,g0 in that order.
- Linearity: parity(A) XOR parity(B) equals parity(A XOR B) for 3 random pairs. Every codeword evaluates to 0 at alpha^0..alpha^15 (bench syndrome check).
- Spacing: the same block is sent with back-to-back CE, then 1-in-8, then random gaps of 1..20 clks -> identical 204-byte output. CEO always exactly 1 clk after CE.
- Reset mid-block: assert reset after data byte 100 -> all outputs 0 immediately. A fresh block then encodes identically to a cold-start reference, with Sync_out on its first byte.

Source files
------------

// File: rtl/rs_enc_if.sv
// Byte-stream bundle between an upstream source and the RS(204,188) encoder.
// master drives the CE strobe and data byte; slave (the encoder) returns the
// encoded byte stream and its qualifying flags.
interface rs_enc_if;
  logic       CE;
  logic [7:0] input_byte;
  logic [7:0] Out_byte;
  logic       CEO;
  logic       Valid_out;
  logic       Sync_out;
  logic       Par_out;

  modport master (
    output CE, input_byte,
    input  Out_byte, CEO, Valid_out, Sync_out, Par_out
  );

  modport slave (
    input  CE, input_byte,
    output Out_byte, CEO, Valid_out, Sync_out, Par_out
  );
endinterface

// File: rtl/rs_enc.sv
// Systematic RS(204,188) encoder over GF(2^8), primitive poly 0x11D, alpha=0x02.
// Data bytes pass straight through while a 16-byte LFSR divides by g(x); the
// remainder is then shifted out as 16 parity bytes. The byte counter wraps at
// N-1, and the LFSR is empty after the last parity shift, so consecutive
// codewords need no idle slot and no explicit clear.
module rs_enc #(
  parameter int N = 204,
  parameter int K = 188
) (
  input  logic    clk,
  input  logic    reset,
  rs_enc_if.slave bus
);

  // Multiply by a constant in GF(2^8); with one operand constant this
  // reduces to a pure XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  // g(x) = prod_{i=0..15} (x + alpha^i), evaluated at elaboration time.
  // Index j holds the coefficient of x^j; index 16 is the monic 1.
  function automatic logic [16:0][7:0] gen_poly();
    logic [16:0][7:0] c;
    logic [7:0]       a;
    c    = '0;
    c[0] = 8'h01;
    a    = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j > 0; j--) c[j] = c[j-1] ^ gf_mul(c[j], a);
      c[0] = gf_mul(c[0], a);
      a    = gf_mul(a, 8'h02);
    end
    return c;
  endfunction

  localparam logic [16:0][7:0] G = gen_poly();

  logic [7:0]       cnt;
  logic [15:0][7:0] r;
  logic [15:0][7:0] r_nxt;
  logic [7:0]       fb;
  logic             data_phase;

  assign data_phase = (cnt < 8'(K));
  assign fb         = bus.input_byte ^ r[15];

  // Next LFSR contents: divide-by-g(x) step for data bytes, plain shift for parity.
  always_comb begin
    r_nxt = '0;
    if (data_phase) begin
      r_nxt[0] = gf_mul(fb, G[0]);
      for (int i = 1; i < 16; i++) r_nxt[i] = r[i-1] ^ gf_mul(fb, G[i]);
    end else begin
      r_nxt[0] = 8'h00;
      for (int i = 1; i < 16; i++) r_nxt[i] = r[i-1];
    end
  end

  // Counter, LFSR and registered outputs; everything advances only on CE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= 8'd0;
      r             <= '0;
      bus.Out_byte  <= 8'h00;
      bus.CEO       <= 1'b0;
      bus.Valid_out <= 1'b0;
      bus.Sync_out  <= 1'b0;
      bus.Par_out   <= 1'b0;
    end else begin
      bus.CEO       <= bus.CE;
      bus.Valid_out <= bus.CE;
      if (bus.CE) begin
        cnt          <= (cnt == 8'(N - 1)) ? 8'd0 : cnt + 8'd1;
        r            <= r_nxt;
        bus.Out_byte <= data_phase ? bus.input_byte : r[15];
        bus.Sync_out <= (cnt == 8'd0);
        bus.Par_out  <= ~data_phase;
      end
    end
  end

endmodule

// File: tb/tb_rs_enc.sv
// Directed bench for rs_enc: expected codewords come from a table-based GF
// model doing polynomial long division, queued as each CE is driven and
// popped when the matching CEO appears.
module tb_rs_enc;

  logic clk = 1'b0;
  logic rst;

  rs_enc_if bus();

  rs_enc #(.N(204), .K(188)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       s;
    logic       p;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] gexp[256];
  int         glog[256];
  logic [7:0] gen[17];
  logic [7:0] blk[188];
  logic [7:0] cw[204];
  logic [7:0] cap[204];
  logic [7:0] ref_cw[204];
  logic [7:0] pa[16];
  logic [7:0] pb[16];
  logic [7:0] ab[188];
  logic       ce_seen;
  int         ceo_cnt;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // Reference codeword from blk[] by long division of m(x)*x^16 by g(x).
  task automatic encode_model();
    logic [7:0] p[204];
    logic [7:0] c;
    for (int j = 0; j < 204; j++) p[j] = (j < 188) ? blk[j] : 8'h00;
    for (int j = 0; j < 188; j++) begin
      c = p[j];
      for (int k = 1; k <= 16; k++) p[j+k] = p[j+k] ^ gm(c, gen[16-k]);
    end
    for (int j = 0; j < 204; j++) cw[j] = (j < 188) ? blk[j] : p[j];
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.CE         = 1'b1;
    bus.input_byte = b;
    @(posedge clk); #1;
    bus.CE         = 1'b0;
    bus.input_byte = 8'($urandom);
    for (int g = 1; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && q.size() != 0; t++) @(posedge clk);
    check("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // mode 0: back-to-back, 1: one CE in 8 clocks, 2: random gaps of 1..20.
  task automatic send_block(input int mode, input int nbytes);
    exp_t e;
    int   gap;
    encode_model();
    for (int j = 0; j < nbytes; j++) begin
      e.b = cw[j];
      e.s = (j == 0);
      e.p = (j >= 188);
      q.push_back(e);
      gap = (mode == 0) ? 1 : (mode == 1) ? 8 : int'($urandom_range(1, 20));
      send_byte((j < 188) ? blk[j] : 8'($urandom), gap);
    end
    drain();
  endtask

  task automatic syndrome_check(input string name);
    logic [7:0] s;
    for (int i = 0; i < 16; i++) begin
      s = 8'h00;
      for (int j = 0; j < 204; j++) s = gm(s, gexp[i]) ^ cap[j];
      check(name, s, 0);
    end
  endtask

  task automatic random_blk();
    for (int j = 0; j < 188; j++) blk[j] = 8'($urandom);
  endtask

  // Output monitor: CEO timing against CE, then scoreboard pop and capture.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      ce_seen <= 1'b0;
      ceo_cnt <= 0;
    end else begin
      check("ceo_timing", bus.CEO, ce_seen);
      check("valid_out", bus.Valid_out, ce_seen);
      ce_seen <= bus.CE;
      if (bus.CEO) begin
        if (q.size() == 0) begin
          check("unexpected_ceo", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_byte", bus.Out_byte, e.b);
          check("sync_out", bus.Sync_out, e.s);
          check("par_out", bus.Par_out, e.p);
        end
        cap[ceo_cnt % 204] <= bus.Out_byte;
        ceo_cnt <= ceo_cnt + 1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    gexp[255] = gexp[0];
    glog[0]   = 0;
    for (int j = 0; j < 17; j++) gen[j] = 8'h00;
    gen[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j > 0; j--) gen[j] = gen[j-1] ^ gm(gen[j], gexp[i]);
      gen[0] = gm(gen[0], gexp[i]);
    end

    // Reset state
    rst            = 1'b1;
    bus.CE         = 1'b0;
    bus.input_byte = 8'h00;
    #23;
    check("rst_out_byte", bus.Out_byte, 0);
    check("rst_ceo", bus.CEO, 0);
    check("rst_valid", bus.Valid_out, 0);
    check("rst_sync", bus.Sync_out, 0);
    check("rst_par", bus.Par_out, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero block
    for (int j = 0; j < 188; j++) blk[j] = 8'h00;
    send_block(0, 204);

    // Unit impulse: parity must be g15..g0
    blk[187] = 8'h01;
    send_block(0, 204);
    for (int k = 0; k < 16; k++) check("impulse_parity", cap[188+k], gen[15-k]);
    syndrome_check("impulse_syndrome");

    // Random blocks, one CE in eight clocks
    for (int b = 0; b < 4; b++) begin
      random_blk();
      send_block(1, 204);
      syndrome_check("random_syndrome");
    end

    // Linearity over three random pairs
    for (int n = 0; n < 3; n++) begin
      random_blk();
      for (int j = 0; j < 188; j++) ab[j] = blk[j];
      send_block(0, 204);
      for (int k = 0; k < 16; k++) pa[k] = cap[188+k];
      random_blk();
      for (int j = 0; j < 188; j++) ab[j] = ab[j] ^ blk[j];
      send_block(0, 204);
      for (int k = 0; k < 16; k++) pb[k] = cap[188+k];
      for (int j = 0; j < 188; j++) blk[j] = ab[j];
      send_block(0, 204);
      for (int k = 0; k < 16; k++) check("linearity", cap[188+k], pa[k] ^ pb[k]);
    end

    // Same block under three CE spacings
    random_blk();
    send_block(0, 204);
    for (int j = 0; j < 204; j++) ref_cw[j] = cap[j];
    send_block(1, 204);
    for (int j = 0; j < 204; j++) check("spacing_1in8", cap[j], ref_cw[j]);
    send_block(2, 204);
    for (int j = 0; j < 204; j++) check("spacing_random", cap[j], ref_cw[j]);

    // Reset after data byte 100, then a fresh block from cold
    random_blk();
    for (int j = 0; j < 188; j++) blk[j][0] = 1'b1;
    send_block(0, 101);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_byte", bus.Out_byte, 0);
    check("midrst_ceo", bus.CEO, 0);
    check("midrst_valid", bus.Valid_out, 0);
    check("midrst_sync", bus.Sync_out, 0);
    check("midrst_par", bus.Par_out, 0);
    q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    random_blk();
    send_block(1, 204);
    syndrome_check("post_reset_syndrome");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
